// File: rtl/rtc_timekeeper.sv
// 24-hour real-time clock: prescaler to one-second ticks, time-of-day counters, load with range check.
// Define RTC_TIMEKEEPER_ALARM_EN to build the hour:minute alarm; otherwise alarm_irq is tied low.
module rtc_timekeeper #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_valid,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_err,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [4:0] hr12,
    output logic       pm,
    output logic       tick,
    output logic       day_roll,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    input  logic       alarm_clr,
    output logic       alarm_irq
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [4:0]    nxt_hr;
    logic [5:0]    nxt_min;
    logic [5:0]    nxt_sec;
    logic          nxt_roll;
    logic          load_ok;
    logic          wrap;

    assign load_ok = set_valid && (set_hr <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
    assign wrap    = run && (presc == PRESC_TOP);

    // Successor time computed in one step so no 60/24 value is ever registered.
    always_comb begin
        nxt_sec  = sec + 6'd1;
        nxt_min  = min;
        nxt_hr   = hr;
        nxt_roll = 1'b0;
        if (sec == 6'd59) begin
            nxt_sec = 6'd0;
            if (min == 6'd59) begin
                nxt_min = 6'd0;
                if (hr == 5'd23) begin
                    nxt_hr   = 5'd0;
                    nxt_roll = 1'b1;
                end else begin
                    nxt_hr = hr + 5'd1;
                end
            end else begin
                nxt_min = min + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            hr       <= '0;
            min      <= '0;
            sec      <= '0;
            tick     <= 1'b0;
            day_roll <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            tick     <= 1'b0;
            day_roll <= 1'b0;
            set_err  <= 1'b0;
            if (load_ok) begin
                hr    <= set_hr;
                min   <= set_min;
                sec   <= set_sec;
                presc <= '0;
            end else begin
                set_err <= set_valid;
                if (wrap) begin
                    presc    <= '0;
                    hr       <= nxt_hr;
                    min      <= nxt_min;
                    sec      <= nxt_sec;
                    tick     <= 1'b1;
                    day_roll <= nxt_roll;
                end else if (run) begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    always_comb begin
        if (hr == 5'd0)
            hr12 = 5'd12;
        else if (hr > 5'd12)
            hr12 = hr - 5'd12;
        else
            hr12 = hr;
    end
    assign pm = (hr >= 5'd12);

`ifdef RTC_TIMEKEEPER_ALARM_EN
    logic alarm_hit;

    // Only a tick-driven advance can hit; loads never raise the alarm.
    assign alarm_hit = wrap && !load_ok && alarm_arm && (nxt_sec == 6'd0) &&
                       (nxt_min == alarm_min) && (nxt_hr == alarm_hr);

    always_ff @(posedge clk) begin
        if (rst)
            alarm_irq <= 1'b0;
        else if (alarm_hit)
            alarm_irq <= 1'b1;
        else if (alarm_clr)
            alarm_irq <= 1'b0;
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_hr, alarm_min, alarm_arm, alarm_clr};
    assign alarm_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper (TICK_DIV=4): seconds-of-day reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_rtc_timekeeper;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hr = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic [4:0] alarm_hr = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       set_err, pm, tick, day_roll, alarm_irq;
    logic [4:0] hr, hr12;
    logic [5:0] min, sec;

    rtc_timekeeper #(.TICK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .set_valid(set_valid),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .set_err(set_err), .hr(hr), .min(min), .sec(sec),
        .hr12(hr12), .pm(pm), .tick(tick), .day_roll(day_roll),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_arm(alarm_arm),
        .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference: time as seconds since midnight, prescaler as a plain count.
    int  m_t = 0, m_p = 0;
    bit  m_tick = 0, m_roll = 0, m_err = 0, m_irq = 0;

    always @(posedge clk) begin
        bit fire;
        fire = 0;
        if (rst) begin
            m_t = 0; m_p = 0; m_tick = 0; m_roll = 0; m_err = 0; m_irq = 0;
        end else begin
            m_tick = 0; m_roll = 0; m_err = 0;
            if (set_valid && set_hr < 24 && set_min < 60 && set_sec < 60) begin
                m_t = set_hr * 3600 + set_min * 60 + set_sec;
                m_p = 0;
            end else begin
                if (set_valid) m_err = 1;
                if (run) begin
                    if (m_p == DIV - 1) begin
                        m_p = 0;
                        m_t = (m_t + 1) % 86400;
                        m_tick = 1;
                        m_roll = (m_t == 0);
                        fire = alarm_arm && (m_t == alarm_hr * 3600 + alarm_min * 60);
                    end else begin
                        m_p = m_p + 1;
                    end
                end
            end
`ifdef RTC_TIMEKEEPER_ALARM_EN
            if (fire) m_irq = 1;
            else if (alarm_clr) m_irq = 0;
`else
            m_irq = 0;
`endif
        end
    end

    always @(negedge clk) begin
        int eh, em, es, e12;
        if (chk_en) begin
            eh = m_t / 3600; em = (m_t / 60) % 60; es = m_t % 60;
            e12 = (eh % 12 == 0) ? 12 : eh % 12;
            vectors++;
            if (hr !== 5'(eh) || min !== 6'(em) || sec !== 6'(es) || hr12 !== 5'(e12) ||
                pm !== (eh >= 12) || tick !== m_tick || day_roll !== m_roll ||
                set_err !== m_err || alarm_irq !== m_irq) begin
                miscompares++;
                $display("FAIL model t=%0t got %0d:%0d:%0d h12=%0d pm=%b tk=%b dr=%b er=%b irq=%b exp %0d:%0d:%0d h12=%0d pm=%b tk=%b dr=%b er=%b irq=%b",
                         $time, hr, min, sec, hr12, pm, tick, day_roll, set_err, alarm_irq,
                         eh, em, es, e12, (eh >= 12), m_tick, m_roll, m_err, m_irq);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load(input int h, input int m, input int s);
        set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_valid = 1'b1;
        cyc(1);
        set_valid = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_hr12", hr12, 12);
        chk("rst_pm", pm, 0);

        // Ticks every fourth cycle from reset.
        run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            chk("tick_cadence", tick, (i % 4 == 0) ? 1 : 0);
        end
        chk("sec_after_12", sec, 3);
        chk("min_after_12", min, 0);

        // Pause holds the partial prescaler count.
        cyc(2);
        run = 1'b0;
        cyc(3);
        run = 1'b1;
        cyc(1);
        chk("resume_no_tick", tick, 0);
        cyc(1);
        chk("resume_tick", tick, 1);
        chk("resume_sec", sec, 4);

        // Day rollover.
        load(23, 59, 58);
        cyc(4);
        chk("pre_roll_sec", sec, 59);
        cyc(4);
        chk("roll_hr", hr, 0);
        chk("roll_sec", sec, 0);
        chk("roll_pulse", day_roll, 1);
        chk("roll_hr12", hr12, 12);
        chk("roll_pm", pm, 0);
        cyc(1);
        chk("roll_pulse_end", day_roll, 0);

        // 12-hour display.
        run = 1'b0;
        load(13, 5, 0);
        chk("h13_hr12", hr12, 1);
        chk("h13_pm", pm, 1);
        chk("load_no_roll", day_roll, 0);
        load(12, 0, 0);
        chk("h12_hr12", hr12, 12);
        chk("h12_pm", pm, 1);

        // Rejected load.
        load(10, 60, 0);
        chk("bad_err", set_err, 1);
        chk("bad_hr", hr, 12);
        chk("bad_min", min, 0);
        cyc(1);
        chk("bad_err_end", set_err, 0);
        load(24, 0, 0);
        chk("bad_hr_err", set_err, 1);

        // Load coinciding with wrap wins, tick discarded.
        run = 1'b1;
        cyc(3);
        load(10, 20, 30);
        chk("coin_tick", tick, 0);
        chk("coin_sec", sec, 30);
        cyc(3);
        chk("coin_hold", sec, 30);
        cyc(1);
        chk("coin_next", sec, 31);

        // Alarm.
        alarm_hr = 5'd7; alarm_min = 6'd30; alarm_arm = 1'b1;
        load(7, 29, 59);
        cyc(4);
        chk("alarm_time_min", min, 30);
`ifdef RTC_TIMEKEEPER_ALARM_EN
        chk("alarm_set", alarm_irq, 1);
        cyc(5);
        chk("alarm_sticky", alarm_irq, 1);
        alarm_clr = 1'b1;
        cyc(1);
        alarm_clr = 1'b0;
        chk("alarm_clr", alarm_irq, 0);
`else
        chk("alarm_off", alarm_irq, 0);
        cyc(5);
        chk("alarm_off_late", alarm_irq, 0);
`endif
        load(7, 30, 0);
        chk("alarm_no_load_trig_sec", sec, 0);
        alarm_arm = 1'b0;

        // Reset mid-count beats a load.
        load(0, 0, 0);
        cyc(2);
        rst = 1'b1;
        load(5, 6, 7);
        rst = 1'b0;
        chk("r2_hr", hr, 0);
        chk("r2_sec", sec, 0);
        chk("r2_tick", tick, 0);
        chk("r2_hr12", hr12, 12);
        chk("r2_irq", alarm_irq, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk("r2_first_tick", tick, (i == 4) ? 1 : 0);
        end
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per one-second tick (legal range 2 or more).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port run  input  1  timekeeping enable; while low, prescaler and time freeze.
REQ-005 SHALL have port set_valid  input  1  time-load request.
REQ-006 SHALL have port set_hr / set_min / set_sec  input  5/6/6  time to load, 24h format.
REQ-007 SHALL have port set_err  output  1  one-cycle pulse: load rejected.
REQ-008 SHALL have port hr / min / sec  output  5/6/6  current time, 24h, registered.
REQ-009 SHALL have port hr12  output  5  display hour, 1..12.
REQ-010 SHALL have port pm  output  1  high when hr >= 12.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each second advance.
REQ-012 SHALL have port day_roll  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.
REQ-013 SHALL have ports alarm_hr / alarm_min  input  5/6, alarm_arm  input  1, alarm_clr  input  1, alarm_irq  output  1.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while run=1, then wrap to 0; tick SHALL assert on the clk edge where the prescaler wraps.
REQ-015 On tick, sec SHALL increment; sec 59 -> 0 with min+1; min 59 -> 0 with hr+1; hr 23 -> 0. All fields SHALL update on the same edge, with no intermediate value of 60 or 24 ever visible.
REQ-016 day_roll SHALL assert on the same edge on which hr/min/sec become 00:00:00 via rollover; it SHALL not assert on a load.
REQ-017 Load: set_valid=1 with set_hr<=23, set_min<=59, set_sec<=59 SHALL load the values on that edge and clear the prescaler to 0; tick SHALL not assert that cycle.
REQ-018 Load with any field out of range SHALL leave time and prescaler unchanged and pulse set_err for one cycle.
REQ-019 A load coinciding with a prescaler wrap SHALL take priority; the tick is discarded.
REQ-020 A load SHALL be accepted regardless of run.
REQ-021 hr12 SHALL be 12 when hr=0, hr-12 when hr>12, otherwise hr; hr12 and pm SHALL be combinational from registered hr, with zero latency.
REQ-022 run=0 SHALL hold the prescaler value; resuming continues from the held count.

Reset
REQ-023 On rst=1 at a clk edge: hr=min=sec=0, prescaler=0, tick=0, day_roll=0, set_err=0, alarm_irq=0; hence hr12=12, pm=0.
REQ-024 rst SHALL take priority over load, tick and alarm in the same cycle; a reset mid-count SHALL discard the partial prescaler count.

Configuration
REQ-025 Macro RTC_TIMEKEEPER_ALARM_EN SHALL gate the alarm logic.
REQ-026 With the macro defined: alarm_irq SHALL set on the edge where time advances by tick to alarm_hr:alarm_min:00 while alarm_arm=1. It SHALL remain set until alarm_clr=1, and a set condition SHALL win over a simultaneous clr. Loads SHALL never trigger it.
REQ-027 Without the macro: alarm ports SHALL remain present, alarm inputs SHALL be ignored, and alarm_irq SHALL be constant 0.

Verification (TICK_DIV=4)
REQ-028 rst, then run=1 for 12 cycles -> tick pulses at cycles 4, 8 and 12; sec=3, min=0, hr=0.
REQ-029 Load 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00 with day_roll=1 for exactly one cycle; hr12=12, pm=0.
REQ-030 Load 13:05:00 -> hr12=1, pm=1. Load 12:00:00 -> hr12=12, pm=1.
REQ-031 set_valid with set_min=60 -> set_err one-cycle pulse; time unchanged. set_valid coinciding with prescaler=3 -> loaded value held, no tick.
REQ-032 ALARM_EN: alarm 07:30, arm=1, load 07:29:59, run 4 cycles -> alarm_irq=1 at 07:30:00 and stays set; clr -> 0. Same sequence without the macro -> alarm_irq stays 0.
REQ-033 rst asserted at prescaler=2 with set_valid=1 -> all outputs at reset values; first tick occurs 4 cycles after rst deasserts.
